// File: rtl/sega_joy_pkg.sv
// rtl/sega_joy_pkg.sv - shared constants for the DB9 Sega/Atari pad scanner
package sega_joy_pkg;

   localparam int JB_UP    = 0;
   localparam int JB_DOWN  = 1;
   localparam int JB_LEFT  = 2;
   localparam int JB_RIGHT = 3;
   localparam int JB_B     = 4;
   localparam int JB_C     = 5;
   localparam int JB_A     = 6;
   localparam int JB_START = 7;
   localparam int JB_Z     = 8;
   localparam int JB_Y     = 9;
   localparam int JB_X     = 10;
   localparam int JB_MODE  = 11;

   localparam logic [7:0] ST_SEL0  = 8'd0;
   localparam logic [7:0] ST_SEL1  = 8'd1;
   localparam logic [7:0] ST_DIR   = 8'd2;
   localparam logic [7:0] ST_START = 8'd3;
   localparam logic [7:0] ST_SIX0  = 8'd4;
   localparam logic [7:0] ST_SIX1  = 8'd5;
   localparam logic [7:0] ST_XYZ   = 8'd6;

   localparam int PIN_UP    = 0;
   localparam int PIN_DOWN  = 1;
   localparam int PIN_LEFT  = 2;
   localparam int PIN_RIGHT = 3;
   localparam int PIN_P6    = 4;
   localparam int PIN_P9    = 5;

   localparam logic [11:0] JOY_RELEASED = 12'hFFF;

endpackage

// File: rtl/sega_joy_pin_sync.sv
// rtl/sega_joy_pin_sync.sv - multi-stage pad pin synchronizer, resets to released (1)
module sega_joy_pin_sync #(
   parameter int WIDTH  = 12,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             res_n_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sync_q [STAGES];

   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         for (int i = 0; i < STAGES; i++) sync_q[i] <= '1;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sega_joy_reader.sv
// rtl/sega_joy_reader.sv - DB9 select driver and two-pad 3/6-button scanner
// Optional 6-button phase (steps 4..6) enabled by SEGA_JOY_6BTN_EN.
module sega_joy_reader
   import sega_joy_pkg::*;
#(
   parameter int LAST_STEP   = 255,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk_i,
   input  logic        res_n_i,
   input  logic        tick_i,
   input  logic [5:0]  joy1_pins_i,
   input  logic [5:0]  joy2_pins_i,
   output logic        joy_p7_o,
   output logic [11:0] joy1_o,
   output logic [11:0] joy2_o,
   output logic [1:0]  six_btn_o,
   output logic        scan_done_o
);

   localparam logic [7:0] LAST = 8'(LAST_STEP);

   logic [11:0] pins_sync;
   logic [5:0]  pins [2];
   logic [7:0]  step_q, step_d;
   logic        p7_q, p7_d;
   logic        done_q, done_d;
   logic [11:0] joy_q [2];
   logic [11:0] joy_d [2];
`ifdef SEGA_JOY_6BTN_EN
   logic [1:0]  flag_q, flag_d;
   logic [1:0]  six_q, six_d;
`endif

   sega_joy_pin_sync #(.WIDTH(12), .STAGES(SYNC_STAGES)) u_pin_sync (
      .clk_i   (clk_i),
      .res_n_i (res_n_i),
      .d_i     ({joy2_pins_i, joy1_pins_i}),
      .q_o     (pins_sync)
   );

   assign pins[0] = pins_sync[5:0];
   assign pins[1] = pins_sync[11:6];

   always_comb begin
      step_d = step_q;
      p7_d   = p7_q;
      done_d = 1'b0;
      joy_d  = joy_q;
`ifdef SEGA_JOY_6BTN_EN
      flag_d = flag_q;
      six_d  = six_q;
`endif
      if (tick_i) begin
         step_d = (step_q == LAST) ? 8'd0 : step_q + 8'd1;
         p7_d   = 1'b1;
         case (step_q)
            ST_SEL0: p7_d = 1'b0;
            ST_SEL1: p7_d = 1'b1;
            ST_DIR: begin
               p7_d = 1'b0;
               for (int p = 0; p < 2; p++) begin
                  joy_d[p][JB_RIGHT:JB_UP] = pins[p][PIN_RIGHT:PIN_UP];
                  joy_d[p][JB_C:JB_B]      = {pins[p][PIN_P9], pins[p][PIN_P6]};
               end
`ifdef SEGA_JOY_6BTN_EN
               flag_d = 2'b00;
`endif
            end
            ST_START: begin
               // Left+right both low while P7 is low only happens on a Mega Drive pad
               for (int p = 0; p < 2; p++) begin
                  if (!pins[p][PIN_RIGHT] && !pins[p][PIN_LEFT])
                     joy_d[p][JB_START:JB_A] = {pins[p][PIN_P9], pins[p][PIN_P6]};
                  else
                     joy_d[p][JB_START:JB_B] = {2'b11, pins[p][PIN_P9], pins[p][PIN_P6]};
               end
`ifndef SEGA_JOY_6BTN_EN
               done_d = 1'b1;
`endif
            end
`ifdef SEGA_JOY_6BTN_EN
            ST_SIX0: p7_d = 1'b0;
            ST_SIX1: begin
               for (int p = 0; p < 2; p++)
                  if (pins[p][PIN_RIGHT:PIN_UP] == 4'h0) flag_d[p] = 1'b1;
            end
            ST_XYZ: begin
               p7_d   = 1'b0;
               done_d = 1'b1;
               six_d  = flag_q;
               for (int p = 0; p < 2; p++)
                  joy_d[p][JB_MODE:JB_Z] = flag_q[p] ? pins[p][PIN_RIGHT:PIN_UP] : 4'hF;
            end
`endif
            default: p7_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         step_q   <= 8'd0;
         p7_q     <= 1'b1;
         done_q   <= 1'b0;
         joy_q[0] <= JOY_RELEASED;
         joy_q[1] <= JOY_RELEASED;
`ifdef SEGA_JOY_6BTN_EN
         flag_q   <= 2'b00;
         six_q    <= 2'b00;
`endif
      end else begin
         step_q   <= step_d;
         p7_q     <= p7_d;
         done_q   <= done_d;
         joy_q[0] <= joy_d[0];
         joy_q[1] <= joy_d[1];
`ifdef SEGA_JOY_6BTN_EN
         flag_q   <= flag_d;
         six_q    <= six_d;
`endif
      end
   end

   assign joy_p7_o    = p7_q;
   assign joy1_o      = joy_q[0];
   assign joy2_o      = joy_q[1];
   assign scan_done_o = done_q;
`ifdef SEGA_JOY_6BTN_EN
   assign six_btn_o   = six_q;
`else
   assign six_btn_o   = 2'b00;
`endif

endmodule

// File: tb/tb_sega_joy_reader.sv
// tb/tb_sega_joy_reader.sv - pad-model bench for sega_joy_reader (honours SEGA_JOY_6BTN_EN)
`timescale 1ns/1ps
module tb_sega_joy_reader;

   localparam int LAST = 255;
`ifdef SEGA_JOY_6BTN_EN
   localparam bit SIX_EN = 1'b1;
`else
   localparam bit SIX_EN = 1'b0;
`endif
   localparam int DONE_STEP = SIX_EN ? 6 : 3;

   // pad kinds: 0 unplugged, 1 Master System, 2 Mega Drive 3-button, 3 Mega Drive 6-button
   logic        clk = 1'b0;
   logic        res_n = 1'b0;
   logic        tick = 1'b0;
   logic [5:0]  pins1, pins2;
   logic        p7;
   logic [11:0] j1, j2;
   logic [1:0]  six;
   logic        done;

   int          total = 0;
   int          bad = 0;
   int          kind1 = 0, kind2 = 0;
   logic [11:0] pr1 = '0, pr2 = '0;
   int          ph = 0, hi_clks = 0;
   logic        p7_prev = 1'b1;
   int          bstep = 0;
   logic        last_done, done_after;

   always #5 clk = ~clk;

   sega_joy_reader #(.LAST_STEP(LAST), .SYNC_STAGES(2)) dut (
      .clk_i       (clk),
      .res_n_i     (res_n),
      .tick_i      (tick),
      .joy1_pins_i (pins1),
      .joy2_pins_i (pins2),
      .joy_p7_o    (p7),
      .joy1_o      (j1),
      .joy2_o      (j2),
      .six_btn_o   (six),
      .scan_done_o (done)
   );

   // pressed masks are active-high in MXYZ SACB RLDU order
   function automatic logic [5:0] pad_pins(input int kind, input logic [11:0] pr,
                                           input logic sel, input int phase);
      logic [11:0] r;
      r = ~pr;
      case (kind)
         1: return {r[5], r[4], r[3:0]};
         2, 3: begin
            if (kind == 3 && phase == 3)
               return sel ? {r[5], r[4], r[11], r[10], r[9], r[8]} : {r[7], r[6], 4'h0};
            if (kind == 3 && phase >= 4 && !sel)
               return {r[7], r[6], 4'hF};
            return sel ? {r[5], r[4], r[3:0]} : {r[7], r[6], 2'b00, r[1:0]};
         end
         default: return 6'h3F;
      endcase
   endfunction

   function automatic logic [11:0] exp_word(input int kind, input logic [11:0] pr);
      logic [11:0] r;
      r = ~pr;
      case (kind)
         1: return {4'hF, 2'b11, r[5:0]};
         2: return {4'hF, r[7:0]};
         3: return SIX_EN ? r : {4'hF, r[7:0]};
         default: return 12'hFFF;
      endcase
   endfunction

   function automatic logic exp_p7(input int s);
      return !((s == 0) || (s == 2) || (SIX_EN && (s == 4 || s == 6)));
   endfunction

   function automatic logic [11:0] clean(input logic [11:0] pr);
      logic [11:0] c;
      c = pr;
      if (c[0] && c[1]) c[1] = 1'b0;
      if (c[2] && c[3]) c[3] = 1'b0;
      return c;
   endfunction

   // 6-button pads count select falling edges and time out after a long high
   always @(posedge clk) begin
      p7_prev <= p7;
      hi_clks <= p7 ? hi_clks + 1 : 0;
      if (p7_prev && !p7) ph <= ph + 1;
      else if (p7 && hi_clks > 100) ph <= 0;
   end

   always_comb begin
      pins1 = pad_pins(kind1, pr1, p7, ph);
      pins2 = pad_pins(kind2, pr2, p7, ph);
   end

   task automatic do_tick();
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
      last_done = done;
      @(negedge clk) done_after = done;
      repeat (3) @(negedge clk);
      bstep = (bstep == LAST) ? 0 : bstep + 1;
   endtask

   task automatic run_scan();
      while (bstep != 0) do_tick();
      repeat (8) do_tick();
   endtask

   task automatic check_scan(input string name);
      logic [11:0] e1, e2;
      logic [1:0]  es;
      e1 = exp_word(kind1, pr1);
      e2 = exp_word(kind2, pr2);
      es = {SIX_EN && kind2 == 3, SIX_EN && kind1 == 3};
      total++; if (j1 !== e1) begin bad++; $display("FAIL %s joy1: got %h want %h", name, j1, e1); end
      total++; if (j2 !== e2) begin bad++; $display("FAIL %s joy2: got %h want %h", name, j2, e2); end
      total++; if (six !== es) begin bad++; $display("FAIL %s six: got %b want %b", name, six, es); end
   endtask

   task automatic test_reset();
      res_n = 1'b0;
      repeat (4) @(negedge clk);
      total++; if (j1 !== 12'hFFF) begin bad++; $display("FAIL reset joy1: got %h want fff", j1); end
      total++; if (j2 !== 12'hFFF) begin bad++; $display("FAIL reset joy2: got %h want fff", j2); end
      total++; if (six !== 2'b00) begin bad++; $display("FAIL reset six: got %b want 00", six); end
      total++; if (p7 !== 1'b1) begin bad++; $display("FAIL reset p7: got %b want 1", p7); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
      res_n = 1'b1;
      bstep = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_idle_scan();
      kind1 = 0; kind2 = 0;
      for (int i = 0; i < 300; i++) begin
         int s;
         s = bstep;
         do_tick();
         if (i < 10) begin
            total++;
            if (p7 !== exp_p7(s)) begin bad++; $display("FAIL idle p7 step %0d: got %b want %b", s, p7, exp_p7(s)); end
            total++;
            if (last_done !== (s == DONE_STEP)) begin bad++; $display("FAIL idle done step %0d: got %b want %b", s, last_done, s == DONE_STEP); end
            total++;
            if (done_after !== 1'b0) begin bad++; $display("FAIL idle done width step %0d: got %b want 0", s, done_after); end
         end
      end
      total++; if (p7 !== 1'b1) begin bad++; $display("FAIL idle p7 hold: got %b want 1", p7); end
      check_scan("idle");
   endtask

   task automatic test_three_btn();
      kind1 = 2; pr1 = 12'h041; kind2 = 0; pr2 = '0;
      run_scan();
      check_scan("three_btn");
      total++; if (j1 !== 12'hFBE) begin bad++; $display("FAIL three_btn literal: got %h want fbe", j1); end
   endtask

   task automatic test_six_btn();
      kind1 = 0; pr1 = '0; kind2 = 3; pr2 = 12'h480;
      run_scan();
      check_scan("six_btn");
      total++;
      if (j2 !== (SIX_EN ? 12'hB7F : 12'hF7F)) begin bad++; $display("FAIL six_btn literal: got %h want %h", j2, SIX_EN ? 12'hB7F : 12'hF7F); end
   endtask

   task automatic test_master_system();
      kind1 = 1; pr1 = 12'h020; kind2 = 0; pr2 = '0;
      run_scan();
      check_scan("master_system");
      total++; if (j1[7:4] !== 4'hD) begin bad++; $display("FAIL ms bits7_4: got %h want d", j1[7:4]); end
      total++; if (j1[11:8] !== 4'hF) begin bad++; $display("FAIL ms bits11_8: got %h want f", j1[11:8]); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) begin
         kind1 = $urandom_range(0, 3); pr1 = clean(12'($urandom));
         kind2 = $urandom_range(0, 3); pr2 = clean(12'($urandom));
         run_scan();
         check_scan("random");
      end
   endtask

   task automatic test_reset_mid_scan();
      int n;
      kind1 = 2; pr1 = 12'h041; kind2 = 3; pr2 = 12'h480;
      run_scan();
      check_scan("pre_reset");
      while (bstep != 5) do_tick();
      @(negedge clk);
      #1 res_n = 1'b0;
      #1;
      total++; if (j1 !== 12'hFFF) begin bad++; $display("FAIL async joy1: got %h want fff", j1); end
      total++; if (j2 !== 12'hFFF) begin bad++; $display("FAIL async joy2: got %h want fff", j2); end
      total++; if (p7 !== 1'b1) begin bad++; $display("FAIL async p7: got %b want 1", p7); end
      total++; if (six !== 2'b00) begin bad++; $display("FAIL async six: got %b want 00", six); end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk) tick = 1'b1;
         @(negedge clk) tick = 1'b0;
      end
      repeat (150) @(negedge clk);
      res_n = 1'b1;
      bstep = 0;
      repeat (2) @(negedge clk);
      n = 0;
      for (int k = 1; k <= 20; k++) begin
         do_tick();
         if (last_done) begin n = k; break; end
      end
      total++; if (n != DONE_STEP + 1) begin bad++; $display("FAIL restart ticks to done: got %0d want %0d", n, DONE_STEP + 1); end
      while (bstep != 8) do_tick();
      check_scan("post_reset");
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_three_btn();
      test_six_btn();
      test_master_system();
      test_random();
      test_reset_mid_scan();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sega_joy_reader.md
Name: sega_joy_reader

Overview:
- Upstream input stage for the arcade tops. Drives the shared DB9 select line (P7) and scans two Atari/Master System/Mega Drive 3- and 6-button pads.
- Produces debounced-by-sampling, active-low 12-bit button words in format MXYZ SACB RLDU.
- The top ORs these words with keyboard-derived controls before the core's input registers.
- Scan is paced by an external line-rate strobe, so one full scan takes many video lines.

Parameters:
- LAST_STEP, 255, final step index before the step counter wraps to 0. Steps 7..LAST_STEP are idle with P7 high, which gives the 6-button pad its reset timeout. Legal range 7..255.
- SYNC_STAGES, 2, number of flip-flop stages on each pad pin input. Legal range 2..3.

Ports:
- clk_i  in  1  system clock
- res_n_i  in  1  asynchronous, active-low reset
- tick_i  in  1  one-clock step strobe (e.g. hsync edge). Minimum spacing is SYNC_STAGES+2 clocks.
- joy1_pins_i  in  6  pad 1 raw pins {p9,p6,right,left,down,up}, active-low
- joy2_pins_i  in  6  pad 2 raw pins, same order
- joy_p7_o  out  1  select line shared by both ports
- joy1_o  out  12  pad 1 word {M,X,Y,Z,S,A,C,B,R,L,D,U}, active-low
- joy2_o  out  12  pad 2 word, same format
- six_btn_o  out  2  bit0 = pad1 and bit1 = pad2 detected as 6-button, active-high
- scan_done_o  out  1  one-clock pulse when the step-6 update commits

Behaviour:
- Reset values (async): step=0, joy_p7_o=1, joy1_o=joy2_o=12'hFFF, six_btn_o=0, scan_done_o=0. Synchronizer flops reset to 1.
- Pin sampling: all 12 pins pass through SYNC_STAGES flops every clock. Every "pin" below means the synchronized value.
- Stepping: each tick_i advances step by 1, wrapping LAST_STEP->0. All actions below execute in the tick_i cycle, for the current step value.
- Step 0: p7<=0.
- Step 1: p7<=1.
- Step 2: per pad, bits[3:0]<={R,L,D,U} and bits[5:4]<={p9,p6}. Clear the internal six-detect flag. p7<=0.
- Step 3, per pad:
  - If R==0 and L==0 (Mega Drive signature): bits[7:6]<={p9,p6}.
  - Otherwise: bits[7:4]<={1,1,p9,p6}.
  - p7<=1.
- Step 4: p7<=0.
- Step 5: per pad, set the six-detect flag if U,D,L,R are all 0. p7<=1.
- Step 6, per pad:
  - If flag set: bits[11:8]<={R,L,D,U}.
  - Otherwise: bits[11:8]<=4'hF.
  - six_btn_o<=flags. p7<=0. scan_done_o pulses in the following clock.
- Steps 7..LAST_STEP: p7<=1, outputs hold.
- Output commit:
  - joy*_o fields update in place at steps 2, 3 and 6.
  - A pad unplugged mid-scan reads all-1 pins, so fields read "released" from the next scan on.
- No tick_i: state frozen, outputs hold indefinitely.
- tick_i during reset: ignored. On reset release the scan restarts at step 0.
- Reset mid-scan: all outputs return to reset values immediately (asynchronously).

Optional Feature:
- Macro: SEGA_JOY_6BTN_EN.
- Defined: full behaviour above.
- Undefined:
  - Steps 4..6 act as idle (p7=1).
  - bits[11:8] stay 4'hF and six_btn_o stays 0.
  - scan_done_o pulses after step 3 instead.

Decomposition:
- Package sega_joy_pkg holds:
  - bit index constants (JB_UP=0 .. JB_MODE=11);
  - step constants ST_SEL0..ST_XYZ (0..6);
  - the pin-vector field indices;
  - JOY_RELEASED=12'hFFF.
- Sub-module sega_joy_pin_sync: parameterised-width, SYNC_STAGES-deep synchronizer with async reset-to-1. One instance covers all 12 pins.

Test Plan:
- Reset, apply 300 ticks with all pins=1 -> joy1_o=joy2_o=12'hFFF, six_btn_o=2'b00, joy_p7_o toggles 0,1,0,1,0,1,0 at steps 0..6, then stays 1.
- Model a 3-button pad on port 1 with A and Up held (P7=0 forces R=L=0, A=p6 low) -> after scan, joy1_o=12'hFBE and six_btn_o[0]=0.
- Model a 6-button pad on port 2 with X and Start held (third P7-low phase drives U/D/L/R=0) -> six_btn_o[1]=1 and joy2_o=12'hB7F.
- Model a Master System pad (no signature) with p9 low on port 1 -> bits[7:4]=4'hD and bits[11:8]=4'hF.
- Assert res_n_i low at step 5 with buttons held -> outputs go to 12'hFFF/p7=1 without a clock. After release, the first scan_done_o arrives after 7 ticks.
- Build without SEGA_JOY_6BTN_EN and drive a 6-button pad model -> joy_p7_o pulses low only at steps 0 and 2, six_btn_o=0, scan_done_o occurs after step 3.
